fetch_unit: RTL

- Instruction-fetch stage directly upstream of decode.
- Holds the PC and issues requests to instruction memory over a req/rdy handshake.
- Buffers one fetched instruction and presents it to decode with a valid flag.
- Accepts redirects for taken branches and jumps, and stops fetching after a HALT (opcode 00000) is captured.

---
 rtl/fetch_unit.sv | 83 ++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches over a req/rdy handshake and
// holds one instruction for decode. Stops fetching once a HALT is captured.
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [4:0]  HALT_OP  = 5'b00000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_in,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_rdy,
  input  logic [15:0] imem_data,
  output logic [15:0] instr,
  output logic [15:0] instr_pc,
  output logic [15:0] pc_plus2,
  output logic        instr_valid,
  output logic        halted,
  output logic        err
);

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  state_t      state_reg;
  logic [15:0] pc_reg;
  logic [15:0] buf_instr_reg;
  logic [15:0] buf_pc_reg;
  logic        buf_valid_reg;
  logic        err_reg;

  logic consume;
  logic fill;
  logic take_redirect;
  logic err_next;

  assign consume       = buf_valid_reg & ~stall_in;
  assign imem_req      = ~rst & (state_reg == RUN) & (~buf_valid_reg | consume);
  assign imem_addr     = pc_reg;
  assign fill          = imem_req & imem_rdy & ~redirect;
  assign take_redirect = redirect & (state_reg == RUN);

  // Misaligned targets are still followed (bit 0 cleared) but are reported.
  assign err_next = redirect & (~buf_valid_reg | stall_in |
                                (state_reg == HALT) | redirect_pc[0]);

  assign instr       = buf_instr_reg;
  assign instr_pc    = buf_pc_reg;
  assign pc_plus2    = buf_pc_reg + 16'd2;
  assign instr_valid = buf_valid_reg;
  assign halted      = (state_reg == HALT);
  assign err         = err_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_reg        <= RESET_PC;
      buf_instr_reg <= 16'h0000;
      buf_pc_reg    <= 16'h0000;
      buf_valid_reg <= 1'b0;
      state_reg     <= RUN;
      err_reg       <= 1'b0;
    end else begin
      err_reg <= err_next;
      if (take_redirect) begin
        // A response arriving alongside the redirect is wrong-path and dropped.
        pc_reg        <= {redirect_pc[15:1], 1'b0};
        buf_valid_reg <= 1'b0;
      end else if (fill) begin
        buf_instr_reg <= imem_data;
        buf_pc_reg    <= pc_reg;
        buf_valid_reg <= 1'b1;
        pc_reg        <= pc_reg + 16'd2;
        if (imem_data[15:11] == HALT_OP) begin
          state_reg <= HALT;
        end
      end else if (consume) begin
        buf_valid_reg <= 1'b0;
      end
    end
  end

endmodule
